// File: rtl/game_state_manager.sv
// Game-rules engine: lives, score, invulnerability window, pickups and win/lose state.
// Input edges are buffered into pending flags and applied on the next animation tick.
module game_state_manager #(
  parameter int unsigned LIVES_W      = 3,
  parameter int unsigned MAX_LIVES    = 3,
  parameter int unsigned START_LIVES  = 2,
  parameter int unsigned SCORE_W      = 10,
  parameter int unsigned WIN_SCORE    = 37,
  parameter int unsigned INVULN_TICKS = 60
) (
  input  logic                 CLOCK,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 pipe_passed,
  input  logic                 score_clear,
  input  logic                 hit,
  input  logic                 bonus,
  input  logic                 penalty,
  output logic [1:0]           state,
  output logic [LIVES_W-1:0]   lives,
  output logic [SCORE_W-1:0]   score,
  output logic                 invuln,
  output logic [MAX_LIVES-1:0] heart_vis,
  output logic                 sfx_point,
  output logic                 sfx_hit
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StWon  = 2'd2,
    StLost = 2'd3
  } state_e;

  localparam logic [LIVES_W-1:0] LivesMax   = LIVES_W'(MAX_LIVES);
  localparam logic [LIVES_W-1:0] LivesStart = LIVES_W'(START_LIVES);
  localparam logic [SCORE_W-1:0] ScoreMax   = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] ScoreWin   = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         CntLoad    = 8'(INVULN_TICKS);

  state_e             r_state;
  logic [LIVES_W-1:0] r_lives;
  logic [SCORE_W-1:0] r_score;
  logic [7:0]         r_cnt;
  logic               r_pipe_q, r_hit_q, r_bonus_q, r_penalty_q;
  logic               r_pend_pt, r_pend_hit, r_pend_bonus, r_pend_penalty;
  logic               r_sfx_point, r_sfx_hit;

  logic               w_pipe_edge, w_hit_edge, w_bonus_edge, w_penalty_edge;
  logic [SCORE_W-1:0] w_score_nx;
  logic               w_win;
  logic [LIVES_W-1:0] w_lives_pick;

  assign w_pipe_edge    = pipe_passed & ~r_pipe_q;
  assign w_hit_edge     = hit & ~r_hit_q;
  assign w_bonus_edge   = bonus & ~r_bonus_q;
  assign w_penalty_edge = penalty & ~r_penalty_q;

  always_comb begin
    w_score_nx = r_score;
    if (r_pend_pt) begin
      if (score_clear) begin
        w_score_nx = '0;
      end else if (r_score != ScoreMax) begin
        w_score_nx = r_score + SCORE_W'(1);
      end
    end
    w_win = (w_score_nx >= ScoreWin);

    w_lives_pick = r_lives;
    if (r_pend_bonus && !r_pend_penalty && (r_lives < LivesMax)) begin
      w_lives_pick = r_lives + LIVES_W'(1);
    end else if (r_pend_penalty && !r_pend_bonus && (r_lives != '0)) begin
      w_lives_pick = r_lives - LIVES_W'(1);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      r_state        <= StIdle;
      r_lives        <= LivesStart;
      r_score        <= '0;
      r_cnt          <= '0;
      r_pipe_q       <= 1'b0;
      r_hit_q        <= 1'b0;
      r_bonus_q      <= 1'b0;
      r_penalty_q    <= 1'b0;
      r_pend_pt      <= 1'b0;
      r_pend_hit     <= 1'b0;
      r_pend_bonus   <= 1'b0;
      r_pend_penalty <= 1'b0;
      r_sfx_point    <= 1'b0;
      r_sfx_hit      <= 1'b0;
    end else begin
      r_pipe_q    <= pipe_passed;
      r_hit_q     <= hit;
      r_bonus_q   <= bonus;
      r_penalty_q <= penalty;
      r_sfx_point <= 1'b0;
      r_sfx_hit   <= 1'b0;
      if (tick) begin
        // Pending flags are consumed now; an edge in this same cycle waits for the next tick.
        r_pend_pt      <= w_pipe_edge;
        r_pend_hit     <= w_hit_edge;
        r_pend_bonus   <= w_bonus_edge;
        r_pend_penalty <= w_penalty_edge;
        unique case (r_state)
          StIdle: begin
            if (start) begin
              r_lives <= LivesStart;
              r_score <= '0;
              r_cnt   <= '0;
              r_state <= StRun;
            end
          end
          StRun: begin
            if (r_pend_pt) begin
              r_score     <= w_score_nx;
              r_sfx_point <= 1'b1;
            end
            if (w_win) begin
              r_state <= StWon;
            end else begin
              r_lives <= w_lives_pick;
              if (r_pend_hit && (r_cnt == '0)) begin
                if (w_lives_pick != '0) begin
                  r_lives   <= w_lives_pick - LIVES_W'(1);
                  r_cnt     <= CntLoad;
                  r_sfx_hit <= 1'b1;
                end else begin
                  r_state <= StLost;
                end
              end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 8'd1;
              end
            end
          end
          StWon, StLost: begin
            if (!start) begin
              r_state <= StIdle;
            end
          end
        endcase
      end else begin
        r_pend_pt      <= r_pend_pt | w_pipe_edge;
        r_pend_hit     <= r_pend_hit | w_hit_edge;
        r_pend_bonus   <= r_pend_bonus | w_bonus_edge;
        r_pend_penalty <= r_pend_penalty | w_penalty_edge;
      end
    end
  end

  always_comb begin
    heart_vis = '0;
    for (int i = 0; i < int'(MAX_LIVES); i++) begin
      heart_vis[i] = (32'(r_lives) > i);
    end
  end

  assign state     = r_state;
  assign lives     = r_lives;
  assign score     = r_score;
  assign invuln    = (r_cnt != '0);
  assign sfx_point = r_sfx_point;
  assign sfx_hit   = r_sfx_hit;

endmodule

// File: tb/tb_game_state_manager.sv
// Directed bench for game_state_manager: one task per scenario, inline comparisons.
module tb_game_state_manager;

  logic       CLOCK = 1'b0;
  logic       reset, tick, start, pipe_passed, score_clear, hit, bonus, penalty;
  logic [1:0] state;
  logic [2:0] lives;
  logic [9:0] score;
  logic       invuln;
  logic [2:0] heart_vis;
  logic       sfx_point, sfx_hit;

  int n_checks = 0;
  int n_pass   = 0;

  game_state_manager dut (
    .CLOCK       (CLOCK),
    .reset       (reset),
    .tick        (tick),
    .start       (start),
    .pipe_passed (pipe_passed),
    .score_clear (score_clear),
    .hit         (hit),
    .bonus       (bonus),
    .penalty     (penalty),
    .state       (state),
    .lives       (lives),
    .score       (score),
    .invuln      (invuln),
    .heart_vis   (heart_vis),
    .sfx_point   (sfx_point),
    .sfx_hit     (sfx_hit)
  );

  always #5 CLOCK = ~CLOCK;

  // One tick cycle; returns at the negedge of the cycle after the tick (sfx visible there).
  task automatic do_tick();
    @(negedge CLOCK) tick = 1'b1;
    @(negedge CLOCK) tick = 1'b0;
  endtask

  // m: bit0 pipe_passed, bit1 hit, bit2 bonus, bit3 penalty -- one rising edge each.
  task automatic pulse(input logic [3:0] m);
    @(negedge CLOCK);
    pipe_passed = m[0]; hit = m[1]; bonus = m[2]; penalty = m[3];
    @(negedge CLOCK);
    pipe_passed = 1'b0; hit = 1'b0; bonus = 1'b0; penalty = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge CLOCK);
    reset = 1'b0;
    @(negedge CLOCK);
    n_checks++;
    if (state !== 2'd0) $display("FAIL reset_state got %0d want 0", state); else n_pass++;
    n_checks++;
    if (lives !== 3'd2) $display("FAIL reset_lives got %0d want 2", lives); else n_pass++;
    n_checks++;
    if (score !== 10'd0 || invuln !== 1'b0 || sfx_point !== 1'b0 || sfx_hit !== 1'b0)
      $display("FAIL reset_misc got score=%0d inv=%b sp=%b sh=%b want 0", score, invuln,
               sfx_point, sfx_hit);
    else n_pass++;
  endtask

  task automatic test_start();
    start = 1'b1;
    do_tick();
    start = 1'b0;
    n_checks++;
    if (state !== 2'd1 || lives !== 3'd2 || score !== 10'd0)
      $display("FAIL start got st=%0d lv=%0d sc=%0d want 1/2/0", state, lives, score);
    else n_pass++;
    n_checks++;
    if (heart_vis !== 3'b011) $display("FAIL start_hearts got %b want 011", heart_vis);
    else n_pass++;
  endtask

  task automatic test_point_collapse();
    repeat (3) pulse(4'b0001);
    do_tick();
    n_checks++;
    if (score !== 10'd1) $display("FAIL collapse_score got %0d want 1", score); else n_pass++;
    n_checks++;
    if (sfx_point !== 1'b1) $display("FAIL collapse_sfx got %b want 1", sfx_point); else n_pass++;
    @(negedge CLOCK);
    n_checks++;
    if (sfx_point !== 1'b0) $display("FAIL sfx_width got %b want 0", sfx_point); else n_pass++;
    do_tick();
    n_checks++;
    if (score !== 10'd1 || sfx_point !== 1'b0)
      $display("FAIL no_repeat got sc=%0d sp=%b want 1/0", score, sfx_point);
    else n_pass++;
  endtask

  task automatic test_hit_invuln();
    int inv_low = 0;
    int hit_pulses = 0;
    pulse(4'b0010);
    do_tick();
    n_checks++;
    if (lives !== 3'd1 || invuln !== 1'b1 || sfx_hit !== 1'b1)
      $display("FAIL hit got lv=%0d inv=%b sh=%b want 1/1/1", lives, invuln, sfx_hit);
    else n_pass++;
    for (int j = 1; j <= 59; j++) begin
      if (j == 29) pulse(4'b0010);
      do_tick();
      if (invuln !== 1'b1) inv_low++;
      if (sfx_hit === 1'b1) hit_pulses++;
    end
    n_checks++;
    if (inv_low != 0) $display("FAIL invuln_hold got %0d low ticks want 0", inv_low);
    else n_pass++;
    n_checks++;
    if (hit_pulses != 0 || lives !== 3'd1)
      $display("FAIL invuln_discard got sh=%0d lv=%0d want 0/1", hit_pulses, lives);
    else n_pass++;
    do_tick();
    n_checks++;
    if (invuln !== 1'b0) $display("FAIL invuln_end got %b want 0", invuln); else n_pass++;
  endtask

  task automatic test_lost_restart();
    pulse(4'b1000);
    do_tick();
    n_checks++;
    if (lives !== 3'd0 || state !== 2'd1)
      $display("FAIL penalty got lv=%0d st=%0d want 0/1", lives, state);
    else n_pass++;
    pulse(4'b1000);
    do_tick();
    n_checks++;
    if (lives !== 3'd0 || state !== 2'd1 || heart_vis !== 3'b000)
      $display("FAIL penalty_floor got lv=%0d st=%0d hv=%b want 0/1/000", lives, state,
               heart_vis);
    else n_pass++;
    pulse(4'b0010);
    do_tick();
    n_checks++;
    if (state !== 2'd3 || sfx_hit !== 1'b0)
      $display("FAIL lost got st=%0d sh=%b want 3/0", state, sfx_hit);
    else n_pass++;
    start = 1'b1;
    do_tick();
    n_checks++;
    if (state !== 2'd3) $display("FAIL lost_hold got %0d want 3", state); else n_pass++;
    start = 1'b0;
    do_tick();
    n_checks++;
    if (state !== 2'd0) $display("FAIL lost_idle got %0d want 0", state); else n_pass++;
    start = 1'b1;
    do_tick();
    start = 1'b0;
    n_checks++;
    if (state !== 2'd1 || lives !== 3'd2 || score !== 10'd0)
      $display("FAIL restart got st=%0d lv=%0d sc=%0d want 1/2/0", state, lives, score);
    else n_pass++;
  endtask

  task automatic test_bonus();
    pulse(4'b0100);
    do_tick();
    n_checks++;
    if (lives !== 3'd3 || heart_vis !== 3'b111)
      $display("FAIL bonus got lv=%0d hv=%b want 3/111", lives, heart_vis);
    else n_pass++;
    pulse(4'b0100);
    do_tick();
    n_checks++;
    if (lives !== 3'd3) $display("FAIL bonus_cap got %0d want 3", lives); else n_pass++;
    pulse(4'b1100);
    do_tick();
    n_checks++;
    if (lives !== 3'd3) $display("FAIL bonus_penalty got %0d want 3", lives); else n_pass++;
    pulse(4'b1000);
    do_tick();
    n_checks++;
    if (lives !== 3'd2) $display("FAIL penalty_dec got %0d want 2", lives); else n_pass++;
  endtask

  task automatic test_win();
    repeat (36) begin
      pulse(4'b0001);
      do_tick();
    end
    n_checks++;
    if (score !== 10'd36 || state !== 2'd1)
      $display("FAIL pre_win got sc=%0d st=%0d want 36/1", score, state);
    else n_pass++;
    pulse(4'b0011);
    do_tick();
    n_checks++;
    if (score !== 10'd37 || state !== 2'd2 || lives !== 3'd2)
      $display("FAIL win got sc=%0d st=%0d lv=%0d want 37/2/2", score, state, lives);
    else n_pass++;
    n_checks++;
    if (sfx_point !== 1'b1 || sfx_hit !== 1'b0)
      $display("FAIL win_sfx got sp=%b sh=%b want 1/0", sfx_point, sfx_hit);
    else n_pass++;
    do_tick();
    start = 1'b1;
    do_tick();
    start = 1'b0;
    repeat (10) begin
      pulse(4'b0001);
      do_tick();
    end
    n_checks++;
    if (score !== 10'd10 || state !== 2'd1)
      $display("FAIL replay got sc=%0d st=%0d want 10/1", score, state);
    else n_pass++;
    score_clear = 1'b1;
    pulse(4'b0011);
    do_tick();
    score_clear = 1'b0;
    n_checks++;
    if (score !== 10'd0 || state !== 2'd1 || lives !== 3'd1 || sfx_hit !== 1'b1)
      $display("FAIL clear_hit got sc=%0d st=%0d lv=%0d sh=%b want 0/1/1/1", score, state,
               lives, sfx_hit);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge CLOCK);
    pipe_passed = 1'b1; tick = 1'b1;
    @(negedge CLOCK);
    pipe_passed = 1'b0; tick = 1'b0;
    n_checks++;
    if (score !== 10'd0) $display("FAIL edge_on_tick got %0d want 0", score); else n_pass++;
    do_tick();
    n_checks++;
    if (score !== 10'd1) $display("FAIL edge_next_tick got %0d want 1", score); else n_pass++;
  endtask

  task automatic test_reset_mid();
    pulse(4'b0001);
    @(negedge CLOCK);
    reset = 1'b1; tick = 1'b1;
    @(negedge CLOCK);
    reset = 1'b0; tick = 1'b0;
    n_checks++;
    if (state !== 2'd0 || score !== 10'd0 || lives !== 3'd2 || invuln !== 1'b0)
      $display("FAIL mid_reset got st=%0d sc=%0d lv=%0d inv=%b want 0/0/2/0", state, score,
               lives, invuln);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; start = 1'b0; pipe_passed = 1'b0; score_clear = 1'b0;
    hit = 1'b0; bonus = 1'b0; penalty = 1'b0;
    test_reset();
    test_start();
    test_point_collapse();
    test_hit_invuln();
    test_lost_restart();
    test_bonus();
    test_win();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
